// File: rtl/sgemm_pkg.sv
// sgemm_pkg
//   Shared constants and types for the SGEMM output serializer.
//   SGEMM_ROW_W  : width of one result row (4 x 32-bit words)
//   SGEMM_ROWS   : rows per result matrix
//   SGEMM_MAT_W  : width of one full result matrix
//   ser_state_e  : serializer FSM state encoding
//   mat_width()  : matrix width for a given row width / row count
//   sat_inc8()   : 8-bit saturating increment
package sgemm_pkg;

    localparam int SGEMM_ROW_W = 128;
    localparam int SGEMM_ROWS  = 4;

    function automatic int mat_width(input int row_w, input int rows);
        return row_w * rows;
    endfunction

    localparam int SGEMM_MAT_W = mat_width(SGEMM_ROW_W, SGEMM_ROWS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/sgemm_frame_buf.sv
// sgemm_frame_buf
//   Two-entry FIFO holding complete result matrices.
//   ref_clk    : clock
//   rst        : synchronous active-high reset (pointers and occupancy)
//   push       : write push_data into the tail entry
//   push_data  : full matrix to store
//   pop        : retire the head entry
//   head_data  : matrix at the head of the FIFO
//   next_row0  : row 0 of the entry behind the head (valid when occ == 2)
//   occ        : occupancy 0..2
//   A push while full is legal only together with a pop; the written slot
//   is the one being retired in that same cycle.
module sgemm_frame_buf
    import sgemm_pkg::*;
#(
    parameter int ROW_W = SGEMM_ROW_W,
    parameter int ROWS  = SGEMM_ROWS
) (
    input  logic                             ref_clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [mat_width(ROW_W,ROWS)-1:0] push_data,
    input  logic                             pop,
    output logic [mat_width(ROW_W,ROWS)-1:0] head_data,
    output logic [ROW_W-1:0]                 next_row0,
    output logic [1:0]                       occ
);

    localparam int MAT_W = mat_width(ROW_W, ROWS);

    logic [MAT_W-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       occ_q;

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge ref_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign next_row0 = mem_q[~rd_ptr_q][ROW_W-1:0];
    assign occ       = occ_q;

endmodule

// File: rtl/sgemm_out_serializer.sv
// sgemm_out_serializer
//   Accepts whole result matrices as single-cycle pulses, buffers up to two,
//   and streams each out one row per handshake.
//   ref_clk   : clock
//   rst       : synchronous active-high reset
//   mat_in    : full matrix, row m at mat_in[ROW_W*m +: ROW_W]
//   mat_valid : one-cycle capture strobe for mat_in (no backpressure)
//   row_out   : current row beat
//   row_valid : row_out holds a valid beat
//   row_ready : downstream accepts the beat
//   row_idx   : index of the current beat
//   row_last  : current beat is the final row of its matrix
//   overflow  : sticky, a matrix was dropped
//   drop_cnt  : dropped matrices, saturating at 255
//
//   state   | meaning
//   --------+----------------------------------------------
//   ST_IDLE | FIFO empty, no beat presented
//   ST_SEND | head matrix draining, row_out holds row row_idx
module sgemm_out_serializer
    import sgemm_pkg::*;
#(
    parameter int ROW_W = SGEMM_ROW_W,
    parameter int ROWS  = SGEMM_ROWS
) (
    input  logic                             ref_clk,
    input  logic                             rst,
    input  logic [mat_width(ROW_W,ROWS)-1:0] mat_in,
    input  logic                             mat_valid,
    output logic [ROW_W-1:0]                 row_out,
    output logic                             row_valid,
    input  logic                             row_ready,
    output logic [1:0]                       row_idx,
    output logic                             row_last,
    output logic                             overflow,
    output logic [7:0]                       drop_cnt
);

    localparam int         MAT_W    = mat_width(ROW_W, ROWS);
    localparam logic [1:0] IDX_LAST = 2'(ROWS - 1);

    ser_state_e       state_q, state_d;
    logic [1:0]       occ;
    logic [MAT_W-1:0] head_data;
    logic [ROW_W-1:0] next_row0;
    logic             hs, hs_last, push, pop, drop;

    logic [ROW_W-1:0] row_out_q, row_out_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [1:0]       idx_inc;
    logic             overflow_q;
    logic [7:0]       drop_cnt_q;

    assign hs      = row_valid && row_ready;
    assign hs_last = hs && row_last;
    // A full FIFO still accepts when its head retires in the same cycle.
    assign push    = mat_valid && ((occ != 2'd2) || hs_last);
    assign drop    = mat_valid && !push;
    assign pop     = hs_last;
    assign idx_inc = row_idx_q + 2'd1;

    sgemm_frame_buf #(
        .ROW_W (ROW_W),
        .ROWS  (ROWS)
    ) u_frame_buf (
        .ref_clk   (ref_clk),
        .rst       (rst),
        .push      (push),
        .push_data (mat_in),
        .pop       (pop),
        .head_data (head_data),
        .next_row0 (next_row0),
        .occ       (occ)
    );

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (push) state_d = ST_SEND;
            ST_SEND: if (hs_last && (occ != 2'd2) && !push) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        row_valid = (state_q == ST_SEND);
        row_last  = row_valid && (row_idx_q == IDX_LAST);
    end

    // Next beat is computed a cycle ahead so row_out is a plain register;
    // on a matrix boundary row 0 comes from the queued entry or straight
    // from mat_in when it is captured into an otherwise empty FIFO.
    always_comb begin
        row_idx_d = row_idx_q;
        row_out_d = row_out_q;
        if (state_q == ST_IDLE) begin
            if (push) begin
                row_idx_d = 2'd0;
                row_out_d = mat_in[ROW_W-1:0];
            end
        end else if (hs_last) begin
            row_idx_d = 2'd0;
            if (occ == 2'd2) begin
                row_out_d = next_row0;
            end else if (push) begin
                row_out_d = mat_in[ROW_W-1:0];
            end else begin
                row_out_d = '0;
            end
        end else if (hs) begin
            row_idx_d = idx_inc;
            row_out_d = head_data[ROW_W*int'(idx_inc) +: ROW_W];
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            row_idx_q  <= 2'd0;
            row_out_q  <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            row_idx_q <= row_idx_d;
            row_out_q <= row_out_d;
            if (drop) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= sat_inc8(drop_cnt_q);
            end
        end
    end

    assign row_out  = row_out_q;
    assign row_idx  = row_idx_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
